// File: rtl/delay_line.sv
`default_nettype none
//==============================================================================
// delay_line : fixed-latency delay of a signed sample stream (register chain or
//              circular RAM buffer) with a primed flag.        Rev 1.0
//==============================================================================
module delay_line #(
   parameter int DATA_WIDTH   = 12,
   parameter int DELAY_CYCLES = 8,
   parameter int SRL_MAX      = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic                         primed
);

   if (DELAY_CYCLES == 0) begin : g_bypass
      assign data_out = data_in;
      assign primed   = 1'b1;
   end else begin : g_delay
      localparam int            CW     = $clog2(DELAY_CYCLES + 1);
      localparam logic [CW-1:0] c_full = CW'(DELAY_CYCLES);

      logic [CW-1:0] count_q, count_d;
      logic          primed_q;

      always_comb begin
         count_d = (count_q == c_full) ? count_q : count_q + 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            count_q  <= '0;
            primed_q <= 1'b0;
         end else begin
            count_q  <= count_d;
            primed_q <= (count_d == c_full);
         end
      end

      assign primed = primed_q;

      if (DELAY_CYCLES <= SRL_MAX) begin : g_chain
         logic signed [DATA_WIDTH-1:0] chain_q [DELAY_CYCLES];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DELAY_CYCLES; i++) chain_q[i] <= '0;
            end else begin
               chain_q[0] <= data_in;
               for (int i = 1; i < DELAY_CYCLES; i++) chain_q[i] <= chain_q[i-1];
            end
         end

         assign data_out = chain_q[DELAY_CYCLES-1];
      end else begin : g_ram
         // N-1 RAM entries plus the output register give exactly N cycles.
         localparam int            DEPTH  = DELAY_CYCLES - 1;
         localparam int            AW     = $clog2(DEPTH);
         localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

         logic signed [DATA_WIDTH-1:0] mem [DEPTH];
         logic [AW-1:0]                wptr_q, wptr_d;
         logic signed [DATA_WIDTH-1:0] out_q;

         always_comb begin
            wptr_d = (wptr_q == c_last) ? '0 : wptr_q + 1'b1;
         end

         always_ff @(posedge clk) begin
            mem[wptr_q] <= data_in;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wptr_q <= '0;
               out_q  <= '0;
            end else begin
               wptr_q <= wptr_d;
               out_q  <= mem[wptr_q];
            end
         end

         // RAM is not cleared on reset, so hide it until real history arrives.
         assign data_out = primed_q ? out_q : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`default_nettype none
//==============================================================================
// tb_delay_line : directed checks of bypass, chain and RAM builds. Rev 1.0
//==============================================================================
module tb_delay_line;
   localparam int DW = 12;

   logic                 clk     = 1'b0;
   logic                 rst     = 1'b0;
   logic signed [DW-1:0] data_in = '0;
   logic signed [DW-1:0] out8, out1, out0, out100, out33r, out33c;
   logic                 pr8, pr1, pr0, pr100, pr33r, pr33c;
   int                   checks  = 0;
   int                   errors  = 0;

   always #5 clk = ~clk;

   delay_line #(.DATA_WIDTH(DW), .DELAY_CYCLES(8)) u_n8 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(out8), .primed(pr8));
   delay_line #(.DATA_WIDTH(DW), .DELAY_CYCLES(1)) u_n1 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(out1), .primed(pr1));
   delay_line #(.DATA_WIDTH(DW), .DELAY_CYCLES(0)) u_n0 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(out0), .primed(pr0));
   delay_line #(.DATA_WIDTH(DW), .DELAY_CYCLES(100)) u_n100 (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(out100), .primed(pr100));
   delay_line #(.DATA_WIDTH(DW), .DELAY_CYCLES(33), .SRL_MAX(32)) u_n33r (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(out33r), .primed(pr33r));
   delay_line #(.DATA_WIDTH(DW), .DELAY_CYCLES(33), .SRL_MAX(33)) u_n33c (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(out33c), .primed(pr33c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Short reset pulse that sits entirely between clock edges.
   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++; if (out8 !== '0)    begin errors++; $display("FAIL reset_out8: got %0d expected 0", out8); end
      checks++; if (pr8 !== 1'b0)   begin errors++; $display("FAIL reset_pr8: got %0b expected 0", pr8); end
      checks++; if (out100 !== '0)  begin errors++; $display("FAIL reset_out100: got %0d expected 0", out100); end
      checks++; if (pr100 !== 1'b0) begin errors++; $display("FAIL reset_pr100: got %0b expected 0", pr100); end
      checks++; if (pr0 !== 1'b1)   begin errors++; $display("FAIL reset_pr0: got %0b expected 1", pr0); end
      #20;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_ramp();
      logic signed [DW-1:0] exp;
      for (int e = 1; e <= 20; e++) begin
         data_in = DW'(10 * (e - 1));
         tick();
         exp = (e >= 8) ? DW'(10 * (e - 8)) : '0;
         checks++;
         if (out8 !== exp) begin errors++; $display("FAIL ramp_out e=%0d: got %0d expected %0d", e, out8, exp); end
         checks++;
         if (pr8 !== (e >= 8)) begin errors++; $display("FAIL ramp_primed e=%0d: got %0b expected %0b", e, pr8, (e >= 8)); end
      end
   endtask

   task automatic test_signed();
      logic signed [DW-1:0] vals [4];
      vals[0] = 12'h800; vals[1] = 12'h7FF; vals[2] = 12'hFFF; vals[3] = 12'h000;
      for (int j = 1; j <= 11; j++) begin
         data_in = (j <= 4) ? vals[j-1] : 12'sd5;
         tick();
         if (j >= 8) begin
            checks++;
            if (out8 !== vals[j-8]) begin errors++; $display("FAIL signed_out j=%0d: got %0d expected %0d", j, out8, vals[j-8]); end
         end
      end
   endtask

   task automatic test_midstream_reset();
      logic signed [DW-1:0] exp;
      for (int e = 1; e <= 10; e++) begin
         data_in = DW'(10 * (e - 1));
         tick();
      end
      checks++; if (pr8 !== 1'b1) begin errors++; $display("FAIL mid_pre_primed: got %0b expected 1", pr8); end
      data_in = 12'sd100;
      #2 rst = 1'b1;
      #1;
      checks++; if (out8 !== '0)    begin errors++; $display("FAIL mid_async_out8: got %0d expected 0", out8); end
      checks++; if (pr8 !== 1'b0)   begin errors++; $display("FAIL mid_async_pr8: got %0b expected 0", pr8); end
      checks++; if (out100 !== '0)  begin errors++; $display("FAIL mid_async_out100: got %0d expected 0", out100); end
      checks++; if (pr100 !== 1'b0) begin errors++; $display("FAIL mid_async_pr100: got %0b expected 0", pr100); end
      #2 rst = 1'b0;
      for (int p = 1; p <= 12; p++) begin
         data_in = DW'(100 + 10 * (p - 1));
         tick();
         exp = (p >= 8) ? DW'(100 + 10 * (p - 8)) : '0;
         checks++;
         if (out8 !== exp) begin errors++; $display("FAIL mid_out p=%0d: got %0d expected %0d", p, out8, exp); end
         checks++;
         if (pr8 !== (p >= 8)) begin errors++; $display("FAIL mid_primed p=%0d: got %0b expected %0b", p, pr8, (p >= 8)); end
      end
   endtask

   task automatic test_short();
      logic signed [DW-1:0] prev;
      logic signed [DW-1:0] v;
      pulse_reset();
      prev = '0;
      checks++; if (pr1 !== 1'b0) begin errors++; $display("FAIL n1_reset_primed: got %0b expected 0", pr1); end
      for (int e = 1; e <= 6; e++) begin
         v = DW'(e * 397 - 1200);
         data_in = v;
         #1;
         checks++;
         if (out0 !== v || pr0 !== 1'b1) begin errors++; $display("FAIL n0_comb e=%0d: got %0d/%0b expected %0d/1", e, out0, pr0, v); end
         checks++;
         if (out1 !== prev) begin errors++; $display("FAIL n1_before e=%0d: got %0d expected %0d", e, out1, prev); end
         tick();
         checks++;
         if (out1 !== v || pr1 !== 1'b1) begin errors++; $display("FAIL n1_after e=%0d: got %0d/%0b expected %0d/1", e, out1, pr1, v); end
         prev = v;
      end
   endtask

   task automatic test_ram_mode();
      logic signed [DW-1:0] stim [1000];
      logic signed [DW-1:0] exp100, exp33;
      pulse_reset();
      for (int k = 1; k <= 1000; k++) begin
         stim[k-1] = DW'($urandom);
         data_in   = stim[k-1];
         tick();
         exp100 = (k >= 100) ? stim[k-100] : '0;
         exp33  = (k >= 33)  ? stim[k-33]  : '0;
         checks++;
         if (out100 !== exp100) begin errors++; $display("FAIL ram100_out k=%0d: got %0d expected %0d", k, out100, exp100); end
         checks++;
         if (pr100 !== (k >= 100)) begin errors++; $display("FAIL ram100_primed k=%0d: got %0b expected %0b", k, pr100, (k >= 100)); end
         checks++;
         if (out33r !== exp33 || pr33r !== (k >= 33)) begin
            errors++; $display("FAIL ram33_out k=%0d: got %0d/%0b expected %0d/%0b", k, out33r, pr33r, exp33, (k >= 33));
         end
         checks++;
         if (out33c !== out33r || pr33c !== pr33r) begin
            errors++; $display("FAIL boundary33 k=%0d: got chain %0d/%0b expected ram %0d/%0b", k, out33c, pr33c, out33r, pr33r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_signed();
      test_midstream_reset();
      test_short();
      test_ram_mode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/delay_line.md
Name: delay_line

Overview:
- Fixed-latency pipeline delay for one signed sample stream, clocked in the pixel clock domain (74.25 MHz class).
- Aligns a data path, e.g. a video/audio sample lane, with a parallel processing path of known latency.
- Small delays use a register shift chain. Large delays use a circular buffer in inferred RAM.
- A "primed" flag marks when the output carries real history.

Parameters:
- DATA_WIDTH, 12, sample width in bits; data is two's-complement signed, passed through unmodified.
- DELAY_CYCLES, 8, latency in clock cycles; legal range 0..4096.
- SRL_MAX, 32, largest DELAY_CYCLES built as a register chain; above this a circular RAM buffer is used.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- data_in  in  DATA_WIDTH (signed)  sample captured every rising clk edge (no enable; stream is continuous).
- data_out  out  DATA_WIDTH (signed)  delayed sample.
- primed  out  1  high once DELAY_CYCLES samples have been captured since reset.

Behaviour:
- Latency definition:
  - With N = DELAY_CYCLES ≥ 1, the sample present on data_in at rising edge k appears on data_out immediately after rising edge k+N-1.
  - This is equivalent to an N-flop chain: data_out is registered and equals data_in as it was N cycles earlier.
- N = 0: data_out is a combinational copy of data_in; primed is tied high.
- Reset, asynchronous and active-high:
  - data_out goes to 0 and primed goes to 0 immediately on rst assertion, without waiting for a clock edge.
  - Register-chain storage is cleared to 0.
  - RAM contents are not cleared. Instead, data_out is forced to 0 while primed = 0, so stale RAM is never visible.
  - The write pointer and fill counter reset to 0.
- Fill counter:
  - Width is clog2(N+1). It increments on each edge after reset and saturates at N.
  - primed = (count == N), and it is registered.
  - The first true sample reaches data_out on the same edge primed rises.
- RAM mode (N > SRL_MAX):
  - Depth is N-1 entries plus the output register.
  - The write pointer wraps from N-2 to 0 exactly, with no power-of-two rounding.
  - The read address equals the write address (read-before-write semantics), feeding the output register.
  - N = SRL_MAX+1 must give the same cycle-level result as chain mode would.
- No arithmetic, saturation or sign change: bit-exact passthrough, including the most negative value (-2048 for 12 bits).
- Reset asserted mid-stream:
  - All in-flight samples are discarded and primed drops.
  - After deassertion, output stays 0 until N new samples have been captured.
- Reset deasserted asynchronously to clk:
  - The first capture is on the first full rising edge after deassertion.
  - The integrating design supplies synchronized deassertion.

Test Plan:
- Reset then ramp, N=8: hold rst for 20 ns, then drive 0,10,20,…,190 one per edge. Required: data_out = 0 and primed = 0 for the first 7 edges; value 0 appears with primed = 1 on edge 8; 10 on edge 9; and so on until 190, exactly 8 cycles after its input edge.
- Signed extremes, N=8: inputs -2048, 2047, -1, 0. Required: identical values out 8 cycles later with no sign corruption.
- Mid-stream reset, N=8: assert rst for one half-cycle while the ramp is at 100. Required: data_out = 0 and primed = 0 immediately without a clock edge; after release, the first nonzero output appears 8 cycles after the first post-reset input.
- N=1 and N=0: with N=1, data_out follows data_in one edge later; with N=0, data_out equals data_in combinationally and primed = 1.
- RAM mode, N=100: random 12-bit stream of 1000 samples. Required: output[k] = input[k-100] for every sample, primed rises exactly at capture 100, and the wrap point shows no glitch.
- Boundary N = SRL_MAX+1 = 33 versus chain N = 33 forced: both builds produce bit-identical output sequences for the same random stimulus.
